// File: rtl/pipe_muxn.sv
// pipe_muxn: N-input operand select captured into a valid/ready pipeline register.
// Define PIPE_MUXN_SKID_EN to add a skid entry and make in_ready a pure register output.
module pipe_muxn #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 3,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] d,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    localparam logic [SEL_W:0] NUM_IN_EXT = (SEL_W + 1)'(NUM_IN);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic [SEL_W-1:0] cap_sel;
    logic [WIDTH-1:0] cap_data;
    logic             accept;
    logic             consume;

`ifdef PIPE_MUXN_SKID_EN
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             in_ready_q;

    assign in_ready = in_ready_q;
`else
    assign in_ready = !out_valid || out_ready;
`endif

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Out-of-range selects fall back to input 0 and report 0 as the effective tag.
    always_comb begin
        cap_sel  = ({1'b0, sel} < NUM_IN_EXT) ? sel : '0;
        cap_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (cap_sel == SEL_W'(i)) begin
                cap_data = d[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
`ifdef PIPE_MUXN_SKID_EN
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
`endif
        if (flush) begin
            state_d     = ST_EMPTY;
            main_data_d = '0;
            main_sel_d  = '0;
`ifdef PIPE_MUXN_SKID_EN
            skid_data_d = '0;
            skid_sel_d  = '0;
`endif
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d     = ST_ONE;
                        main_data_d = cap_data;
                        main_sel_d  = cap_sel;
                    end
                end
                ST_ONE: begin
                    if (accept) begin
`ifdef PIPE_MUXN_SKID_EN
                        if (consume) begin
                            main_data_d = cap_data;
                            main_sel_d  = cap_sel;
                        end else begin
                            state_d     = ST_TWO;
                            skid_data_d = cap_data;
                            skid_sel_d  = cap_sel;
                        end
`else
                        main_data_d = cap_data;
                        main_sel_d  = cap_sel;
`endif
                    end else if (consume) begin
                        state_d = ST_EMPTY;
                    end
                end
`ifdef PIPE_MUXN_SKID_EN
                // in_ready is low here, so the only event is the skid draining into main.
                ST_TWO: begin
                    if (consume) begin
                        state_d     = ST_ONE;
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                        skid_data_d = '0;
                        skid_sel_d  = '0;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
`ifdef PIPE_MUXN_SKID_EN
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
`ifdef PIPE_MUXN_SKID_EN
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= (state_d != ST_TWO);
`endif
        end
    end

endmodule

// File: tb/tb_pipe_muxn.sv
// Self-checking bench for pipe_muxn: directed and random beats against a queue reference model.
// Builds with or without PIPE_MUXN_SKID_EN; the model's ready rule follows the same macro.
module tb_pipe_muxn;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 3;
    localparam int SEL_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_IN*WIDTH-1:0] d;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_valid;
    logic                    out_ready;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] tag;
    } beat_t;

    beat_t            model[$];
    logic [WIDTH-1:0] words[NUM_IN];
    bit               heldZero;
    bit               lastAccepted;
    int               numChecks;
    int               numFails;
    int               consumed;
    int               beatNum;
    int               guard;
    int               accepts;
    int               pattern[4] = '{1, 0, 0, 1};

    pipe_muxn #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .d         (d),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Occupancy-based ready: the skid build holds two beats, the plain build one beat
    // but frees its slot in the same cycle the downstream consumes.
    function automatic bit expReady(input bit ordy);
`ifdef PIPE_MUXN_SKID_EN
        return model.size() < 2;
`else
        return (model.size() == 0) || ordy;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        numChecks++;
        assert (obs === exp)
        else begin
            numFails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [SEL_W-1:0] s, input bit ordy, input bit fl);
        bit               acc;
        bit               cons;
        logic [SEL_W-1:0] eff;
        beat_t            b;
        for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = words[i];
        in_valid  = v;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        #1;
        checkOutput("in_ready", in_ready, expReady(ordy));
        checkOutput("out_valid", out_valid, model.size() > 0);
        if (model.size() > 0) begin
            checkOutput("out_data", out_data, model[0].data);
            checkOutput("out_sel", out_sel, model[0].tag);
        end else if (heldZero) begin
            checkOutput("idle_data_zero", out_data, 0);
            checkOutput("idle_sel_zero", out_sel, 0);
        end
        acc    = v && expReady(ordy);
        cons   = (model.size() > 0) && ordy;
        eff    = (int'(s) < NUM_IN) ? s : '0;
        b.data = words[eff];
        b.tag  = eff;
        @(posedge clk);
        #1;
        if (cons) begin
            void'(model.pop_front());
            consumed++;
        end
        if (fl) begin
            model.delete();
            heldZero = 1'b1;
        end else if (acc) begin
            model.push_back(b);
            heldZero = 1'b0;
        end
        lastAccepted = acc && !fl;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        numChecks = 0;
        numFails  = 0;
        consumed  = 0;
        heldZero  = 1'b1;
        for (int i = 0; i < NUM_IN; i++) words[i] = '0;
        d         = '0;
        sel       = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_sel", out_sel, 0);

        words = '{32'hA, 32'hB, 32'hC};
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        checkOutput("first_beat_data", out_data, 32'hB);
        checkOutput("first_beat_sel", out_sel, 1);
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
        checkOutput("sel_oob_data", out_data, 32'hA);
        checkOutput("sel_oob_sel", out_sel, 0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

        consumed = 0;
        beatNum  = 1;
        guard    = 0;
        while ((beatNum <= 8 || model.size() > 0) && guard < 100) begin
            for (int i = 0; i < NUM_IN; i++) words[i] = beatNum * 256 + i;
            applyStimulus(beatNum <= 8, 2'($urandom_range(0, 2)),
                          (beatNum > 8) ? 1'b1 : 1'(pattern[guard % 4]), 1'b0);
            if (lastAccepted) beatNum++;
            guard++;
        end
        checkOutput("stream_all_out", consumed, 8);
        checkOutput("stream_in_budget", guard < 100, 1);

        for (int i = 0; i < NUM_IN; i++) words[i] = $urandom;
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        for (int i = 0; i < NUM_IN; i++) words[i] = 32'hDEAD_0000 + i;
        applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_data", out_data, 0);
        for (int i = 0; i < NUM_IN; i++) words[i] = 32'h5EED_0000 + i;
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < NUM_IN; i++) words[i] = 32'hBAD0_0000 + i;
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NUM_IN; i++) words[i] = $urandom;
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end

        for (int i = 0; i < NUM_IN; i++) words[i] = $urandom;
        applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", out_valid, 0);
        checkOutput("async_rst_data", out_data, 0);
        checkOutput("async_rst_sel", out_sel, 0);
        model.delete();
        heldZero = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < NUM_IN; i++) words[i] = 32'hF00D_0000 + i;
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        checkOutput("post_rst_first", out_data, 32'hF00D_0002);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

`ifndef PIPE_MUXN_SKID_EN
        for (int i = 0; i < NUM_IN; i++) words[i] = $urandom;
        applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        #1;
        checkOutput("noskid_ready_low", in_ready, 0);
        out_ready = 1'b1;
        #1;
        checkOutput("noskid_ready_comb", in_ready, 1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
`endif

        accepts = 0;
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NUM_IN; i++) words[i] = $urandom;
            applyStimulus(1'b1, 2'($urandom_range(0, 2)), 1'b1, 1'b0);
            if (lastAccepted) accepts++;
        end
        checkOutput("throughput", accepts, 10);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
